sar_search_ctrl: RTL and testbench

//  Initiator side of the 16-bit magnitude-compare interface. Finds an unknown

---
 rtl/sar_search_if.sv | 39 +++
 rtl/sar_search_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sar_search_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_if.sv
// Magnitude-compare initiator bus: search handshake, comparator flags and probe operand.
// Optional probe counter port enabled by SAR_PROBE_CNT_EN.
interface sar_search_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

`ifdef SAR_PROBE_CNT_EN
  localparam int unsigned CW = $clog2(WIDTH + 2);
  logic [CW-1:0]    probe_cnt;

  modport master (
    input  start, gt, lt, eq,
    output probe, busy, done, result, found, err, probe_cnt
  );
  modport slave (
    output start, gt, lt, eq,
    input  probe, busy, done, result, found, err, probe_cnt
  );
`else
  modport master (
    input  start, gt, lt, eq,
    output probe, busy, done, result, found, err
  );
  modport slave (
    output start, gt, lt, eq,
    input  probe, busy, done, result, found, err
  );
`endif
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search against an external magnitude comparator, MSB first.
// Optional per-search probe counter enabled by SAR_PROBE_CNT_EN.
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.master bus
);
  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    VERIFY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] acc_upd;
  logic             flags_ok;

`ifdef SAR_PROBE_CNT_EN
  localparam int unsigned CW = $clog2(WIDTH + 2);
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef SAR_PROBE_CNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
`ifdef SAR_PROBE_CNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state and output decode; done is a single-cycle pulse by default-low
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    probe_d  = probe_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
`ifdef SAR_PROBE_CNT_EN
    cnt_d    = cnt_q;
`endif
    bit_k    = WIDTH'(1) << k_q;
    acc_upd  = acc_q;
    flags_ok = ({bus.gt, bus.lt, bus.eq} == 3'b100) ||
               ({bus.gt, bus.lt, bus.eq} == 3'b010) ||
               ({bus.gt, bus.lt, bus.eq} == 3'b001);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PROBE;
          k_d     = KW'(WIDTH - 1);
          acc_d   = '0;
          probe_d = WIDTH'(1) << (WIDTH - 1);
          busy_d  = 1'b1;
          found_d = 1'b0;
          err_d   = 1'b0;
`ifdef SAR_PROBE_CNT_EN
          cnt_d   = CW'(1);
`endif
        end
      end

      PROBE: begin
        if (!flags_ok) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = probe_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (bus.eq) begin
          result_d = probe_q;
          found_d  = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          // lt means the target is above the probe, so the trial bit stays
          acc_upd = bus.lt ? (acc_q | bit_k) : acc_q;
          acc_d   = acc_upd;
          if (k_q != '0) begin
            k_d     = k_q - KW'(1);
            probe_d = acc_upd | (WIDTH'(1) << (k_q - KW'(1)));
          end else begin
            probe_d = acc_upd;
            state_d = VERIFY;
          end
`ifdef SAR_PROBE_CNT_EN
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end

      VERIFY: begin
        if (!flags_ok) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = probe_q;
        end else begin
          found_d  = bus.eq;
          result_d = acc_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.probe  = probe_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
`ifdef SAR_PROBE_CNT_EN
  assign bus.probe_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: comparator model with a target register, vector table
// plus hand-written corner sequences, expectations queued at start and checked at done.
module tb_sar_search_ctrl;
  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [15:0] target;
    logic [15:0] result;
    logic        found;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic        found;
    logic        err;
    int          cycles;
    int          cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] target;
  logic        force_en;
  logic [2:0]  force_flags;
  logic        prev_done;
  int          checks;
  int          errors;
  exp_t        sb_q[$];
  vec_t        vecs[8];

  sar_search_if #(.WIDTH(WIDTH)) bus ();

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Comparator model: probe on a, target on b, optional forced flag pattern
  assign bus.gt = force_en ? force_flags[2] : (bus.probe > target);
  assign bus.lt = force_en ? force_flags[1] : (bus.probe < target);
  assign bus.eq = force_en ? force_flags[0] : (bus.probe == target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Invariants every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
      chk("done_twice", 32'(bus.done & prev_done), 32'd0);
      prev_done = bus.done;
    end
  end

  // Launch a search, optionally forcing flags / retargeting / pulsing start mid-search
  task automatic run(input string nm, input logic [15:0] tgt, input exp_t e,
                     input int force_at, input int retarget_at, input logic [15:0] new_tgt,
                     input bit pulse_busy);
    int          cycles;
    exp_t        x;
    logic [15:0] held;
    target   = tgt;
    force_en = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 0;
    chk({nm, "_busy_first"}, 32'(bus.busy), 32'd1);
    chk({nm, "_probe_first"}, 32'(bus.probe), 32'h8000);
    while (!bus.done && cycles < 40) begin
      if (force_at != 0 && cycles == force_at - 1) begin
        force_flags = 3'b000;
        force_en    = 1'b1;
      end
      if (retarget_at != 0 && cycles == retarget_at) target = new_tgt;
      bus.start = pulse_busy && (cycles == 3 || cycles == 8);
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    force_en  = 1'b0;
    chk({nm, "_done_seen"}, 32'(bus.done), 32'd1);
    x = sb_q.pop_front();
    chk({nm, "_latency"}, 32'(cycles), 32'(x.cycles));
    chk({nm, "_result"}, 32'(bus.result), 32'(x.result));
    chk({nm, "_found"}, 32'(bus.found), 32'(x.found));
    chk({nm, "_err"}, 32'(bus.err), 32'(x.err));
`ifdef SAR_PROBE_CNT_EN
    chk({nm, "_probe_cnt"}, 32'(bus.probe_cnt), 32'(x.cnt));
`endif
    held = bus.probe;
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, "_probe_hold"}, 32'(bus.probe), 32'(held));
    chk({nm, "_result_hold"}, 32'(bus.result), 32'(x.result));
  endtask

  initial begin
    int   cycles;
    exp_t e;

    // Probe counts follow from the lowest set bit of the target (17 for target 0)
    vecs[0] = '{16'h8000, 16'h8000, 1'b1, 1};
    vecs[1] = '{16'h0000, 16'h0000, 1'b1, 17};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16};
    vecs[3] = '{16'h1234, 16'h1234, 1'b1, 14};
    vecs[4] = '{16'h0001, 16'h0001, 1'b1, 16};
    vecs[5] = '{16'h4000, 16'h4000, 1'b1, 2};
    vecs[6] = '{16'h00F0, 16'h00F0, 1'b1, 12};
    vecs[7] = '{16'h0100, 16'h0100, 1'b1, 8};

    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    target      = 16'h0000;
    force_en    = 1'b0;
    force_flags = 3'b000;
    prev_done   = 1'b0;
    bus.start   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_probe", 32'(bus.probe), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_found", 32'(bus.found), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
`ifdef SAR_PROBE_CNT_EN
    chk("rst_probe_cnt", 32'(bus.probe_cnt), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      e = '{vecs[i].result, vecs[i].found, 1'b0, vecs[i].cycles, vecs[i].cycles};
      run($sformatf("vec%0d", i), vecs[i].target, e, 0, 0, 16'h0, 1'b0);
    end

    // Flags 000 on probe 3 for target 0x1234: probes 8000,4000,2000
    e = '{16'h2000, 1'b0, 1'b1, 3, 3};
    run("abort", 16'h1234, e, 3, 0, 16'h0, 1'b0);

    // Retarget 0x1234->0x5678 after E5: acc 0x1000 with bit 11 cleared, rest all lt
    e = '{16'h17FF, 1'b0, 1'b0, 17, 17};
    run("retarget", 16'h1234, e, 0, 5, 16'h5678, 1'b1);

    // Start held through the done edge: ignored there, accepted one cycle later
    target = 16'h8000;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_done", 32'(bus.done), 32'd1);
    chk("hold_busy_low", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("hold_restart_busy", 32'(bus.busy), 32'd1);
    chk("hold_restart_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    chk("hold_second_done", 32'(bus.done), 32'd1);
    chk("hold_second_latency", 32'(cycles), 32'd1);
    chk("hold_second_result", 32'(bus.result), 32'h8000);

    // Reset mid-search after E7
    target = 16'h1234;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_probe", 32'(bus.probe), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_found", 32'(bus.found), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    chk("midrst_no_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    e = '{16'h1234, 1'b1, 1'b0, 14, 14};
    run("post_rst", 16'h1234, e, 0, 0, 16'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
